rec_byte_assembler: RTL and testbench



---
 rtl/rec_pkg.sv | 27 ++
 rtl/rec_byte_assembler_if.sv | 24 ++
 rtl/rec_out_reg.sv | 33 +++
 rtl/rec_byte_assembler.sv | 144 ++++++++++++++
 tb/tb_rec_byte_assembler.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/rec_pkg.sv
// Shared types and constants for the byte-to-record assembler.
package rec_pkg;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] payload;
    logic       flag;
  } rec_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GOT_ADDR    = 2'd1,
    GOT_PAYLOAD = 2'd2,
    HOLD        = 2'd3
  } asm_state_e;

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_FORMAT  = 2'b10;
  localparam logic [1:0] ERR_PARITY  = 2'b11;

  localparam int REC_W = $bits(rec_t);

  function automatic logic even_parity(input logic [15:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rec_byte_assembler_if.sv
// Byte-in / record-out / error-strobe bundle for rec_byte_assembler.
interface rec_byte_assembler_if;
  import rec_pkg::*;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  rec_t       out_rec;
  logic       out_valid;
  logic       out_ready;
  logic       err_valid;
  logic [1:0] err_code;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_rec, out_valid, err_valid, err_code
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_rec, out_valid, err_valid, err_code
  );

endinterface

// File: rtl/rec_out_reg.sv
// Output holding register: keeps a record stable until the consumer takes it.
module rec_out_reg
  import rec_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  rec_t i_rec,
  input  logic i_ready,
  output logic o_valid,
  output rec_t o_rec
);

  logic r_valid;
  rec_t r_rec;

  // Load wins over drain so a record completing during a handshake is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_rec   <= {REC_W{1'b0}};
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_rec   <= i_rec;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_rec   = r_rec;

endmodule

// File: rtl/rec_byte_assembler.sv
// Assembles addr/payload/flag byte triples into rec_t records with timeout and format checks.
// Optional flag parity check enabled by defining REC_PARITY_CHECK_EN.
module rec_byte_assembler
  import rec_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  rec_byte_assembler_if.slave  bus
);

  localparam int              CW       = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CW-1:0]   LAST_CNT = (TIMEOUT_CYCLES > 32'sd0) ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};

  asm_state_e    r_state;
  logic [7:0]    r_addr;
  logic [7:0]    r_payload;
  logic [CW-1:0] r_cnt;
  logic          r_err_valid;
  logic [1:0]    r_err_code;

  logic w_in_ready;
  logic w_accept;
  logic w_fmt_bad;
  logic w_par_bad;
  logic w_load;
  logic w_expire;
  logic w_out_valid;
  rec_t w_rec;
  rec_t w_out_rec;

  // Handshake qualification and byte2 checks.
  always_comb begin
    w_in_ready = (r_state == HOLD) ? bus.out_ready : 1'b1;
    w_accept   = bus.in_valid && w_in_ready;
    w_fmt_bad  = (bus.in_data[7:1] != 7'b000_0000);
`ifdef REC_PARITY_CHECK_EN
    w_par_bad  = (bus.in_data[0] != even_parity({r_addr, r_payload}));
`else
    w_par_bad  = 1'b0;
`endif
    w_load     = (r_state == GOT_PAYLOAD) && w_accept && !w_fmt_bad && !w_par_bad;
    // Counter has already seen TIMEOUT_CYCLES-1 idle cycles; this idle cycle expires it.
    w_expire   = (TIMEOUT_CYCLES > 32'sd0) && ((r_state == GOT_ADDR) || (r_state == GOT_PAYLOAD))
                 && !w_accept && (r_cnt == LAST_CNT);
    w_rec      = {r_addr, r_payload, bus.in_data[0]};
  end

  // Frame FSM with idle-cycle timeout and registered error reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= 8'h00;
      r_payload   <= 8'h00;
      r_cnt       <= {CW{1'b0}};
      r_err_valid <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_err_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= {CW{1'b0}};
          if (w_accept) begin
            r_addr  <= bus.in_data;
            r_state <= GOT_ADDR;
          end
        end
        GOT_ADDR: begin
          if (w_accept) begin
            r_payload <= bus.in_data;
            r_cnt     <= {CW{1'b0}};
            r_state   <= GOT_PAYLOAD;
          end else if (w_expire) begin
            r_cnt       <= {CW{1'b0}};
            r_err_valid <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1'b1);
          end
        end
        GOT_PAYLOAD: begin
          if (w_accept) begin
            r_cnt <= {CW{1'b0}};
            if (w_fmt_bad) begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_FORMAT;
              r_state     <= IDLE;
            end else if (w_par_bad) begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_PARITY;
              r_state     <= IDLE;
            end else begin
              r_state <= HOLD;
            end
          end else if (w_expire) begin
            r_cnt       <= {CW{1'b0}};
            r_err_valid <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1'b1);
          end
        end
        HOLD: begin
          r_cnt <= {CW{1'b0}};
          // A byte taken during the output handshake starts the next frame.
          if (w_out_valid && bus.out_ready) begin
            if (w_accept) begin
              r_addr  <= bus.in_data;
              r_state <= GOT_ADDR;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_cnt   <= {CW{1'b0}};
          r_state <= IDLE;
        end
      endcase
    end
  end

  rec_out_reg u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_rec   (w_rec),
    .i_ready (bus.out_ready),
    .o_valid (w_out_valid),
    .o_rec   (w_out_rec)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_rec   = w_out_rec;
  assign bus.err_valid = r_err_valid;
  assign bus.err_code  = r_err_code;

endmodule

// File: tb/tb_rec_byte_assembler.sv
// Directed self-checking bench for rec_byte_assembler (TIMEOUT_CYCLES = 16).
module tb_rec_byte_assembler;
  import rec_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   err_cnt;
  rec_t rec_q[$];

  rec_byte_assembler_if bus();

  rec_byte_assembler #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record and error observers, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) rec_q.push_back(bus.out_rec);
    if (bus.err_valid) err_cnt = err_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && waited < 20) begin
      cyc();
      waited++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: in_ready=%b required 1 for byte %h", bus.in_ready, b);
    end
    cyc();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    rec_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.out_rec !== 17'h00000) begin failures++; $display("FAIL reset_out_rec: got %h required 00000", bus.out_rec); end
    checks++; if (bus.err_valid !== 1'b0) begin failures++; $display("FAIL reset_err_valid: got %b required 0", bus.err_valid); end
    checks++; if (bus.err_code !== 2'b00) begin failures++; $display("FAIL reset_err_code: got %b required 00", bus.err_code); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    drain();
    send_byte(8'hA5);
    send_byte(8'h3C);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b required 0", bus.out_valid); end
    send_byte(8'h01);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b required 1", bus.out_valid); end
    checks++; if (bus.out_rec !== 17'h14A79) begin failures++; $display("FAIL basic_rec: got %h required 14a79", bus.out_rec); end
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle: got %b required 0", bus.out_valid); end
    checks++; if (rec_q.size() !== 1) begin failures++; $display("FAIL basic_count: got %0d required 1", rec_q.size()); end
  endtask

  task automatic test_back_to_back();
    drain();
    bus.out_ready = 1'b0;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h00);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h56;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_hold_ready[%0d]: got %b required 0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_hold_valid[%0d]: got %b required 1", i, bus.out_valid); end
      checks++; if (bus.out_rec !== 17'h02468) begin failures++; $display("FAIL b2b_hold_rec[%0d]: got %h required 02468", i, bus.out_rec); end
      cyc();
    end
    bus.out_ready = 1'b1;
    #1;
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h01);
    checks++; if (bus.out_rec !== 17'h0ACF1) begin failures++; $display("FAIL b2b_second_rec: got %h required 0acf1", bus.out_rec); end
    cyc();
    checks++; if (rec_q.size() !== 2) begin failures++; $display("FAIL b2b_count: got %0d required 2", rec_q.size()); end
    if (rec_q.size() == 2) begin
      checks++; if (rec_q[0] !== 17'h02468) begin failures++; $display("FAIL b2b_first_out: got %h required 02468", rec_q[0]); end
      checks++; if (rec_q[1] !== 17'h0ACF1) begin failures++; $display("FAIL b2b_second_out: got %h required 0acf1", rec_q[1]); end
    end
  endtask

  task automatic test_timeout();
    int e0;
    drain();
    e0 = err_cnt;
    send_byte(8'h10);
    repeat (15) cyc();
    checks++; if (bus.err_valid !== 1'b0) begin failures++; $display("FAIL to_early: err_valid=%b required 0", bus.err_valid); end
    cyc();
    checks++; if (bus.err_valid !== 1'b1) begin failures++; $display("FAIL to_pulse: err_valid=%b required 1", bus.err_valid); end
    checks++; if (bus.err_code !== 2'b01) begin failures++; $display("FAIL to_code: got %b required 01", bus.err_code); end
    cyc();
    checks++; if (bus.err_valid !== 1'b0) begin failures++; $display("FAIL to_pulse_end: err_valid=%b required 0", bus.err_valid); end
    checks++; if (err_cnt !== e0 + 1) begin failures++; $display("FAIL to_count: got %0d required %0d", err_cnt, e0 + 1); end
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h01);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL to_next_valid: got %b required 1", bus.out_valid); end
    checks++; if (bus.out_rec !== 17'h04061) begin failures++; $display("FAIL to_next_rec: got %h required 04061", bus.out_rec); end
    // Bytes arriving exactly on the expiry cycle must win.
    e0 = err_cnt;
    send_byte(8'h10);
    repeat (15) cyc();
    send_byte(8'h22);
    repeat (15) cyc();
    send_byte(8'h01);
    checks++; if (bus.out_rec !== 17'h02045) begin failures++; $display("FAIL to_edge_rec: got %h required 02045", bus.out_rec); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL to_edge_valid: got %b required 1", bus.out_valid); end
    checks++; if (err_cnt !== e0) begin failures++; $display("FAIL to_edge_noerr: got %0d required %0d", err_cnt, e0); end
  endtask

  task automatic test_format();
    drain();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h03);
    checks++; if (bus.err_valid !== 1'b1) begin failures++; $display("FAIL fmt_pulse: got %b required 1", bus.err_valid); end
    checks++; if (bus.err_code !== 2'b10) begin failures++; $display("FAIL fmt_code: got %b required 10", bus.err_code); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fmt_no_valid: got %b required 0", bus.out_valid); end
    cyc();
    checks++; if (bus.err_code !== 2'b10) begin failures++; $display("FAIL fmt_code_held: got %b required 10", bus.err_code); end
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h00);
    checks++; if (bus.out_rec !== 17'h06688) begin failures++; $display("FAIL fmt_next_rec: got %h required 06688", bus.out_rec); end
    cyc();
    checks++; if (rec_q.size() !== 1) begin failures++; $display("FAIL fmt_count: got %0d required 1", rec_q.size()); end
  endtask

  task automatic test_parity();
    drain();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef REC_PARITY_CHECK_EN
    checks++; if (bus.err_valid !== 1'b1) begin failures++; $display("FAIL par_pulse: got %b required 1", bus.err_valid); end
    checks++; if (bus.err_code !== 2'b11) begin failures++; $display("FAIL par_code: got %b required 11", bus.err_code); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL par_no_valid: got %b required 0", bus.out_valid); end
`else
    checks++; if (bus.err_valid !== 1'b0) begin failures++; $display("FAIL par_off_noerr: got %b required 0", bus.err_valid); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL par_off_valid: got %b required 1", bus.out_valid); end
    checks++; if (bus.out_rec !== 17'h00200) begin failures++; $display("FAIL par_off_rec: got %h required 00200", bus.out_rec); end
`endif
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL par_good_valid: got %b required 1", bus.out_valid); end
    checks++; if (bus.out_rec !== 17'h00201) begin failures++; $display("FAIL par_good_rec: got %h required 00201", bus.out_rec); end
  endtask

  task automatic test_async_reset();
    int e0;
    drain();
    e0 = err_cnt;
    send_byte(8'h5A);
    send_byte(8'h6B);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_rec !== 17'h00000) begin failures++; $display("FAIL ar_out_rec: got %h required 00000", bus.out_rec); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.err_code !== 2'b00) begin failures++; $display("FAIL ar_err_code: got %b required 00", bus.err_code); end
    checks++; if (bus.err_valid !== 1'b0) begin failures++; $display("FAIL ar_err_valid: got %b required 0", bus.err_valid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h01);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ar_fresh_valid: got %b required 1", bus.out_valid); end
    checks++; if (bus.out_rec !== 17'h00205) begin failures++; $display("FAIL ar_fresh_rec: got %h required 00205", bus.out_rec); end
    cyc();
    checks++; if (err_cnt !== e0) begin failures++; $display("FAIL ar_no_err: got %0d required %0d", err_cnt, e0); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    err_cnt  = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_format();
    test_parity();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
